// File: rtl/riscv_pkg.sv
// Shared core definitions: writeback source encodings, load funct3 codes
// and the default datapath/register-file dimensions.
package riscv_pkg;

   localparam int DEFAULT_DATA_WIDTH   = 32;
   localparam int DEFAULT_NUM_REGISTER = 32;

   localparam logic [1:0] WB_ALU  = 2'b00;
   localparam logic [1:0] WB_LOAD = 2'b01;
   localparam logic [1:0] WB_PC4  = 2'b10;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Combinational load lane selection and sign/zero extension, with detection
// of misaligned halfword/word accesses and unknown load types.
module load_align
   import riscv_pkg::*;
#(
   parameter int DW = DEFAULT_DATA_WIDTH
) (
   input  logic [DW-1:0] i_mem_rdata,
   input  logic [1:0]    i_offset,
   input  logic [2:0]    i_funct3,
   output logic [DW-1:0] o_data,
   output logic          o_err
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = i_mem_rdata[{i_offset, 3'b000} +: 8];
      half_lane = i_mem_rdata[{i_offset[1], 4'b0000} +: 16];
      o_data    = '0;
      o_err     = 1'b0;
      case (i_funct3)
         F3_LB:  o_data = {{(DW-8){byte_lane[7]}}, byte_lane};
         F3_LBU: o_data = {{(DW-8){1'b0}}, byte_lane};
         F3_LH: begin
            o_data = {{(DW-16){half_lane[15]}}, half_lane};
            o_err  = i_offset[0];
         end
         F3_LHU: begin
            o_data = {{(DW-16){1'b0}}, half_lane};
            o_err  = i_offset[0];
         end
         F3_LW: begin
            o_data = i_mem_rdata;
            o_err  = |i_offset;
         end
         default: o_err = 1'b1;
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: selects and registers the writeback value, drives the
// register-file write port plus its forwarding copy, and counts retirements.
module writeback_stage
   import riscv_pkg::*;
#(
   parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
   parameter int NUM_REGISTER = DEFAULT_NUM_REGISTER,
   localparam int AW          = $clog2(NUM_REGISTER)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_valid,
   input  logic                  i_flush,
   input  logic                  i_rd_en,
   input  logic [AW-1:0]         i_rd_addr,
   input  logic [1:0]            i_wb_sel,
   input  logic [2:0]            i_funct3,
   input  logic [DATA_WIDTH-1:0] i_alu_result,
   input  logic [DATA_WIDTH-1:0] i_mem_rdata,
   input  logic [DATA_WIDTH-1:0] i_pc_plus4,
   output logic                  o_we,
   output logic [AW-1:0]         o_rd_addr,
   output logic [DATA_WIDTH-1:0] o_rd,
   output logic                  o_fwd_valid,
   output logic [AW-1:0]         o_fwd_addr,
   output logic [DATA_WIDTH-1:0] o_fwd_data,
   output logic                  o_load_err,
   output logic [63:0]           o_instret
);

   logic [DATA_WIDTH-1:0] load_data;
   logic                  load_err;

   load_align #(.DW(DATA_WIDTH)) u_load_align (
      .i_mem_rdata (i_mem_rdata),
      .i_offset    (i_alu_result[1:0]),
      .i_funct3    (i_funct3),
      .o_data      (load_data),
      .o_err       (load_err)
   );

   logic                  valid_d;
   logic                  we_d, we_q;
   logic                  err_d, err_q;
   logic [AW-1:0]         rd_addr_d, rd_addr_q;
   logic [DATA_WIDTH-1:0] rd_d, rd_q;
   logic [63:0]           instret_d, instret_q;

   // The write enable and error are resolved before the register, so the
   // registered copies already carry the bubble/flush/x0 qualification.
   always_comb begin
      valid_d   = i_valid & ~i_flush;
      rd_addr_d = i_rd_addr;
      case (i_wb_sel)
         WB_ALU:  rd_d = i_alu_result;
         WB_LOAD: rd_d = load_data;
         WB_PC4:  rd_d = i_pc_plus4;
         default: rd_d = '0;
      endcase
      err_d     = valid_d & (i_wb_sel == WB_LOAD) & load_err;
      we_d      = valid_d & i_rd_en & (i_rd_addr != '0) & ~err_d & (i_wb_sel != 2'b11);
      instret_d = instret_q + 64'(valid_d & ~err_d);
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         we_q      <= 1'b0;
         err_q     <= 1'b0;
         rd_addr_q <= '0;
         rd_q      <= '0;
         instret_q <= '0;
      end else begin
         we_q      <= we_d;
         err_q     <= err_d;
         rd_addr_q <= rd_addr_d;
         rd_q      <= rd_d;
         instret_q <= instret_d;
      end
   end

   assign o_we        = we_q;
   assign o_rd_addr   = rd_addr_q;
   assign o_rd        = rd_q;
   assign o_fwd_valid = we_q;
   assign o_fwd_addr  = rd_addr_q;
   assign o_fwd_data  = rd_q;
   assign o_load_err  = err_q;
   assign o_instret   = instret_q;

endmodule
